// File: rtl/servo_pwm_pkg.sv
// Shared constants, FSM state type and width clamp for servo_pwm_ctrl.
// Imported by servo_pwm_tick and servo_pwm_ctrl.
package servo_pwm_pkg;

  localparam int DEF_W            = 16;
  localparam int DEF_TICK_DIV     = 100;
  localparam int DEF_FRAME_US     = 20000;
  localparam int DEF_MIN_US       = 1000;
  localparam int DEF_MAX_US       = 2000;
  localparam int DEF_CENTER_US    = 1500;
  localparam int DEF_RAMP_STEP_US = 10;

  typedef enum logic {
    OFF,
    RUN
  } state_t;

  function automatic int unsigned clamp_us(
    input int unsigned v,
    input int unsigned lo,
    input int unsigned hi
  );
    int unsigned r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_tick.sv
// Microsecond prescaler and frame counter for the servo scheduler.
// Ports: clk, rst (sync, active-high), run (0 holds both counters at 0),
// tick (last clk of each us), fcnt (us within frame), frame_end (last clk of frame).
module servo_pwm_tick
  import servo_pwm_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int FRAME_US = DEF_FRAME_US
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic         tick,
  output logic [W-1:0] fcnt,
  output logic         frame_end
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;

  assign tick      = run && (pre == PW'(TICK_DIV - 1));
  assign frame_end = tick && (fcnt == W'(FRAME_US - 1));

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pre  <= '0;
      fcnt <= '0;
    end else begin
      if (tick) pre <= '0;
      else      pre <= pre + 1'b1;
      if (tick) begin
        if (frame_end) fcnt <= '0;
        else           fcnt <= fcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Single-channel servo pulse scheduler driving a 3-state pin buffer.
// Ports: clk, rst (sync, active-high), enable, cmd_valid/cmd_ready/cmd_width_us
// (width command handshake), cmd_clamped (out-of-range pulse), active_width_us,
// frame_start, pwm_out (pin data), pwm_t (pin 3-state, 1 = high-Z).
// Optional macro SERVO_PWM_RAMP_EN: slew toward a persistent target per frame.
module servo_pwm_ctrl
  import servo_pwm_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int FRAME_US  = DEF_FRAME_US,
  parameter int MIN_US    = DEF_MIN_US,
  parameter int MAX_US    = DEF_MAX_US,
  parameter int CENTER_US = DEF_CENTER_US
`ifdef SERVO_PWM_RAMP_EN
  , parameter int RAMP_STEP_US = DEF_RAMP_STEP_US
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_width_us,
  output logic         cmd_clamped,
  output logic [W-1:0] active_width_us,
  output logic         frame_start,
  output logic         pwm_out,
  output logic         pwm_t
);

  state_t state, state_n;

  logic         tick;
  logic         frame_end;
  logic [W-1:0] fcnt;
  logic [W-1:0] fcnt_n;

  logic         start;
  logic         bound;
  logic         xfer;
  logic         oor;
  int unsigned  clamp_res;
  logic [W-1:0] width_c;
  logic [W-1:0] active_n;

  logic pwm_n;
  logic pwm_t_n;
  logic fs_n;
  logic clamped_n;

  servo_pwm_tick #(
    .W        (W),
    .TICK_DIV (TICK_DIV),
    .FRAME_US (FRAME_US)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .run       (state == RUN),
    .tick      (tick),
    .fcnt      (fcnt),
    .frame_end (frame_end)
  );

  assign clamp_res = clamp_us(32'(cmd_width_us), MIN_US, MAX_US);
  assign width_c   = W'(clamp_res);
  assign oor       = (clamp_res != 32'(cmd_width_us));
  assign xfer      = cmd_valid && cmd_ready;

  // start: a new frame begins on this edge.
  // bound: a width update point (start from OFF, or any frame end).
  always_comb begin
    state_n = state;
    start   = 1'b0;
    bound   = 1'b0;
    unique case (state)
      OFF: begin
        bound = enable;
        if (enable) begin
          state_n = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        bound = frame_end;
        if (frame_end) begin
          start = enable;
          if (!enable) state_n = OFF;
        end
      end
    endcase
  end

`ifndef SERVO_PWM_RAMP_EN

  logic         pend_full, pend_full_n;
  logic [W-1:0] pend_val, pend_val_n;

  assign cmd_ready = !pend_full;

  // Load and transfer are exclusive: a transfer needs an empty slot,
  // a load needs a full one, so a boundary transfer waits one frame.
  always_comb begin
    pend_full_n = pend_full;
    pend_val_n  = pend_val;
    active_n    = active_width_us;
    if (bound && pend_full) begin
      active_n    = pend_val;
      pend_full_n = 1'b0;
    end
    if (xfer) begin
      pend_full_n = 1'b1;
      pend_val_n  = width_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_val  <= W'(CENTER_US);
    end else begin
      pend_full <= pend_full_n;
      pend_val  <= pend_val_n;
    end
  end

`else

  logic [W-1:0] tgt, tgt_n;
  logic [W-1:0] diff;
  logic [W-1:0] step;

  assign cmd_ready = 1'b1;

  always_comb begin
    tgt_n = xfer ? width_c : tgt;
    if (tgt > active_width_us) diff = tgt - active_width_us;
    else                       diff = active_width_us - tgt;
    if (diff > W'(RAMP_STEP_US)) step = W'(RAMP_STEP_US);
    else                         step = diff;
    active_n = active_width_us;
    if (bound) begin
      if (tgt > active_width_us) active_n = active_width_us + step;
      else                       active_n = active_width_us - step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tgt <= W'(CENTER_US);
    else     tgt <= tgt_n;
  end

`endif

  // pwm_out is registered against the count the counter moves to on
  // this edge, so the high time is exactly active*TICK_DIV clocks.
  always_comb begin
    fcnt_n = fcnt;
    if (start)     fcnt_n = '0;
    else if (tick) fcnt_n = fcnt + 1'b1;
    pwm_n     = (state_n == RUN) && (fcnt_n < active_n);
    pwm_t_n   = (state_n != RUN);
    fs_n      = start;
    clamped_n = xfer && oor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= OFF;
      pwm_out         <= 1'b0;
      pwm_t           <= 1'b1;
      frame_start     <= 1'b0;
      cmd_clamped     <= 1'b0;
      active_width_us <= W'(CENTER_US);
    end else begin
      state           <= state_n;
      pwm_out         <= pwm_n;
      pwm_t           <= pwm_t_n;
      frame_start     <= fs_n;
      cmd_clamped     <= clamped_n;
      active_width_us <= active_n;
    end
  end

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Self-checking bench for servo_pwm_ctrl (small timing constants).
// Vector table + scoreboard queue of expected per-frame widths.
`timescale 1ns/1ps
module tb_servo_pwm_ctrl;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int FR = 100;
  localparam int MN = 10;
  localparam int MX = 20;
  localparam int CE = 15;
  localparam int FRAME_CYC = TD * FR;
`ifdef SERVO_PWM_RAMP_EN
  localparam int RS = 2;
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_width_us;
  logic         cmd_clamped;
  logic [W-1:0] active_width_us;
  logic         frame_start;
  logic         pwm_out;
  logic         pwm_t;

  always #5 clk = ~clk;

  servo_pwm_ctrl #(
    .W         (W),
    .TICK_DIV  (TD),
    .FRAME_US  (FR),
    .MIN_US    (MN),
    .MAX_US    (MX),
    .CENTER_US (CE)
`ifdef SERVO_PWM_RAMP_EN
    , .RAMP_STEP_US (RS)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_width_us    (cmd_width_us),
    .cmd_clamped     (cmd_clamped),
    .active_width_us (active_width_us),
    .frame_start     (frame_start),
    .pwm_out         (pwm_out),
    .pwm_t           (pwm_t)
  );

  typedef struct {
    logic [W-1:0] cmd;
    logic [W-1:0] exp_w;
    bit           exp_clamp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] sb_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on the first cycle of a frame; returns on the first cycle
  // of the next frame with the high and total cycle counts.
  task automatic run_frame(input bit do_cmd,
                           input logic [W-1:0] w,
                           input int at,
                           input bit exp_clamp,
                           output int high,
                           output int len);
    high = 0;
    len  = 0;
    for (int c = 0; c < 1000; c++) begin
      len++;
      if (pwm_out === 1'b1) high++;
      if (do_cmd && c == at) begin
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_width_us = w;
      end
      step();
      if (do_cmd && c == at) begin
        cmd_valid = 1'b0;
        check("cmd_clamped", cmd_clamped, exp_clamp);
        check("ready_after_cmd", cmd_ready, RAMP);
      end
      if (frame_start === 1'b1) return;
    end
    check("frame_timeout", len, FRAME_CYC);
  endtask

  initial begin
    int hi;
    int ln;
    int fs_cnt;
    int t_low;
    logic [W-1:0] cur;
    logic [W-1:0] ew;
    vec_t vecs[10];
    logic [W-1:0] ramp_w[4];

    vecs = '{
      '{16'd18,    16'd18, 1'b0},
      '{16'd5,     16'd10, 1'b1},
      '{16'd30,    16'd20, 1'b1},
      '{16'd10,    16'd10, 1'b0},
      '{16'd20,    16'd20, 1'b0},
      '{16'd0,     16'd10, 1'b1},
      '{16'd21,    16'd20, 1'b1},
      '{16'd9,     16'd10, 1'b1},
      '{16'hFFFF,  16'd20, 1'b1},
      '{16'd12,    16'd12, 1'b0}
    };
    ramp_w = '{16'd17, 16'd19, 16'd20, 16'd20};

    rst          = 1'b1;
    enable       = 1'b0;
    cmd_valid    = 1'b0;
    cmd_width_us = '0;
    repeat (3) step();
    check("rst_pwm_t", pwm_t, 1);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_clamped", cmd_clamped, 0);
    check("rst_fs", frame_start, 0);
    check("rst_active", active_width_us, CE);

    rst = 1'b0;
    repeat (3) step();
    check("off_pwm_t", pwm_t, 1);
    check("off_fs", frame_start, 0);

    enable = 1'b1;
    step();
    check("start_fs", frame_start, 1);
    check("start_pwm_t", pwm_t, 0);
    check("start_pwm_out", pwm_out, 1);
    cur = CE;

    run_frame(1'b0, '0, 0, 1'b0, hi, ln);
    check("f0_high", hi, cur * TD);
    check("f0_len", ln, FRAME_CYC);

`ifndef SERVO_PWM_RAMP_EN
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(vecs[i].exp_w);
      run_frame(1'b1, vecs[i].cmd, 20, vecs[i].exp_clamp, hi, ln);
      check("vec_high_old", hi, cur * TD);
      check("vec_len", ln, FRAME_CYC);
      check("vec_ready_boundary", cmd_ready, 1);
      ew = sb_q.pop_front();
      check("vec_active", active_width_us, ew);
      cur = ew;
    end

    // transfer on the boundary edge waits one more frame
    sb_q.push_back(16'd13);
    run_frame(1'b1, 16'd13, FRAME_CYC - 1, 1'b0, hi, ln);
    check("bnd_high", hi, cur * TD);
    check("bnd_active_unchanged", active_width_us, cur);
    run_frame(1'b0, '0, 0, 1'b0, hi, ln);
    check("bnd_high_next", hi, cur * TD);
    ew = sb_q.pop_front();
    check("bnd_active_loaded", active_width_us, ew);
    check("bnd_ready", cmd_ready, 1);
    cur = ew;

    // enable dropped mid-frame: pulse completes, then pin released
    hi = 0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (pwm_out === 1'b1) hi++;
      if (c == 20) enable = 1'b0;
      if (c == FRAME_CYC - 1) check("drop_t_last", pwm_t, 0);
      step();
    end
    check("drop_high", hi, cur * TD);
    check("drop_pwm_t", pwm_t, 1);
    check("drop_pwm_out", pwm_out, 0);
    check("drop_fs", frame_start, 0);
    fs_cnt = 0;
    t_low  = 0;
    for (int c = 0; c < 500; c++) begin
      if (frame_start === 1'b1) fs_cnt++;
      if (pwm_t !== 1'b1) t_low++;
      step();
    end
    check("off_no_fs", fs_cnt, 0);
    check("off_t_high", t_low, 0);

    // command accepted in OFF loads on the start edge
    cmd_valid    = 1'b1;
    cmd_width_us = 16'd12;
    step();
    cmd_valid = 1'b0;
    check("off_cmd_ready", cmd_ready, 0);
    check("off_cmd_clamped", cmd_clamped, 0);
    check("off_active_hold", active_width_us, cur);
    enable = 1'b1;
    step();
    check("restart_fs", frame_start, 1);
    check("restart_active", active_width_us, 12);
    check("restart_ready", cmd_ready, 1);
    cur = 16'd12;
    run_frame(1'b0, '0, 0, 1'b0, hi, ln);
    check("restart_high", hi, cur * TD);
`else
    for (int i = 0; i < 4; i++) sb_q.push_back(ramp_w[i]);
    run_frame(1'b1, 16'd20, 20, 1'b0, hi, ln);
    check("ramp_high0", hi, cur * TD);
    for (int i = 0; i < 4; i++) begin
      ew = sb_q.pop_front();
      check("ramp_active", active_width_us, ew);
      cur = ew;
      run_frame(1'b0, '0, 0, 1'b0, hi, ln);
      check("ramp_high", hi, cur * TD);
      check("ramp_len", ln, FRAME_CYC);
    end
`endif

    // reset during the high phase, with a command outstanding
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        cmd_valid    = 1'b1;
        cmd_width_us = 16'd18;
      end
      step();
      cmd_valid = 1'b0;
    end
    check("pre_rst_high", pwm_out, 1);
    rst = 1'b1;
    step();
    check("mid_rst_pwm_out", pwm_out, 0);
    check("mid_rst_pwm_t", pwm_t, 1);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_active", active_width_us, CE);
    check("mid_rst_fs", frame_start, 0);
    rst = 1'b0;
    step();
    check("post_rst_fs", frame_start, 1);
    check("post_rst_pwm_t", pwm_t, 0);
    run_frame(1'b0, '0, 0, 1'b0, hi, ln);
    check("post_rst_high", hi, CE * TD);
    check("post_rst_len", ln, FRAME_CYC);
    check("post_rst_active", active_width_us, CE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
